gf2_poly_divider: RTL and testbench

- Sequential GF(2) polynomial long divider. It is the inverse of the binary Karatsuba carry-less multipliers: given dividend a(x) and divisor b(x), it returns q(x) and r(x) with a = q·b ⊕ r and deg r < deg b.
- Used to reduce carry-less products and to check them in the FPU multiplier datapath.
- Processes one quotient bit per cycle after normalizing the divisor.

---
 rtl/gf2_div_pkg.sv | 17 +
 rtl/gf2_div_step.sv | 23 ++
 rtl/gf2_poly_divider.sv | 134 +++++++++++++
 tb/tb_gf2_poly_divider.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_div_pkg.sv
// Shared sizing and state encoding for the sequential GF(2) polynomial divider.
package gf2_div_pkg;

  localparam int DW = 19;
  localparam int VW = 10;
  localparam int QW = DW;
  localparam int RW = VW - 1;
  localparam int SW = $clog2(VW);
  // Iteration counter must hold DW + (VW-1).
  localparam int NW = $clog2(DW + VW);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/gf2_div_step.sv
// One long-division iteration over GF(2): shift in one dividend bit, conditionally subtract (XOR) the normalized divisor.
module gf2_div_step
  import gf2_div_pkg::*;
(
  input  logic [RW-1:0] r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] b_i,
  output logic [RW-1:0] r_o,
  output logic          qbit_o
);

  logic [VW-1:0] t;
  logic [VW-1:0] t_sub;

  always_comb begin
    t      = {r_i, bit_i};
    qbit_o = t[VW-1];
    // b_i has its MSB set, so the XOR always clears t[VW-1] when qbit is 1.
    t_sub  = qbit_o ? (t ^ b_i) : t;
    r_o    = t_sub[RW-1:0];
  end

endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2) polynomial divider: normalizes the divisor, then produces one quotient bit per cycle.
module gf2_poly_divider
  import gf2_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [QW-1:0] quotient_o,
  output logic [RW-1:0] remainder_o,
  output logic          div_zero_o
);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [VW-1:0] b_q, b_d;
  logic [RW-1:0] r_q, r_d;
  logic [QW-1:0] q_q, q_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic          valid_q, valid_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [RW-1:0] step_r;
  logic          step_qbit;
  logic [QW-1:0] q_shift;

  // a_q shifts left each DIV cycle and fills with zeros, giving the a(x)*x^s stream.
  gf2_div_step u_step (
    .r_i    (r_q),
    .bit_i  (a_q[DW-1]),
    .b_i    (b_q),
    .r_o    (step_r),
    .qbit_o (step_qbit)
  );

  assign q_shift = {q_q[QW-2:0], step_qbit};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    s_d     = s_q;
    n_d     = n_q;
    valid_d = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = dividend_i;
          b_d     = divisor_i;
          s_d     = '0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (b_q == '0) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          quo_d   = '0;
          rem_d   = '0;
          dz_d    = 1'b1;
        end else if (!b_q[VW-1]) begin
          b_d = b_q << 1;
          s_d = s_q + SW'(1);
        end else begin
          r_d     = '0;
          q_d     = '0;
          n_d     = NW'(DW) + NW'(s_q);
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        a_d = a_q << 1;
        r_d = step_r;
        q_d = q_shift;
        n_d = n_q - NW'(1);
        if (n_q == NW'(1)) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          quo_d   = q_shift;
          // Remainder was computed against b*x^s, so undo the normalization shift.
          rem_d   = step_r >> s_q;
          dz_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Working datapath registers are only meaningful once loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    r_q <= r_d;
    q_q <= q_d;
    s_q <= s_d;
    n_q <= n_d;
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign valid_o     = valid_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and randomized checks for the sequential GF(2) polynomial divider.
module tb_gf2_poly_divider;
  import gf2_div_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [DW-1:0] dividend_i;
  logic [VW-1:0] divisor_i;
  logic          ready_o;
  logic          valid_o;
  logic [QW-1:0] quotient_o;
  logic [RW-1:0] remainder_o;
  logic          div_zero_o;

  int n_assert;
  int n_fail;

  gf2_poly_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] clmul(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) if (y[i]) p = p ^ (x << i);
    return p;
  endfunction

  function automatic int degree(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Issue one request from IDLE and wait (bounded) for valid_o; lat = -1 on timeout.
  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       output logic [QW-1:0] q, output logic [RW-1:0] r,
                       output logic dz, output int lat);
    int cyc;
    @(posedge clk); #1;
    start_i = 1'b1; dividend_i = a; divisor_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; dividend_i = '1; divisor_i = '0;
    cyc = 1; lat = -1; q = '0; r = '0; dz = 1'b0;
    while (cyc < 100 && lat < 0) begin
      if (valid_o) begin
        lat = cyc; q = quotient_o; r = remainder_o; dz = div_zero_o;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_assert += 5;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    if (quotient_o !== '0) begin n_fail++; $display("FAIL reset_q got %h want 0", quotient_o); end
    if (remainder_o !== '0) begin n_fail++; $display("FAIL reset_r got %h want 0", remainder_o); end
    if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b want 0", div_zero_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [DW-1:0] va [4] = '{19'h00005, 19'h00007, 19'h7FFFF, 19'h40000};
    logic [VW-1:0] vb [4] = '{10'h003,   10'h003,   10'h001,   10'h200};
    logic [QW-1:0] vq [4] = '{19'h00003, 19'h00002, 19'h7FFFF, 19'h00200};
    logic [RW-1:0] vr [4] = '{9'h000,    9'h001,    9'h000,    9'h000};
    int            vl [4] = '{37, 37, 39, 21};
    logic [QW-1:0] q; logic [RW-1:0] r; logic dz; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], q, r, dz, lat);
      n_assert += 4;
      if (q !== vq[i]) begin n_fail++; $display("FAIL dir%0d_q got %h want %h", i, q, vq[i]); end
      if (r !== vr[i]) begin n_fail++; $display("FAIL dir%0d_r got %h want %h", i, r, vr[i]); end
      if (dz !== 1'b0) begin n_fail++; $display("FAIL dir%0d_dz got %b want 0", i, dz); end
      if (lat != vl[i]) begin n_fail++; $display("FAIL dir%0d_lat got %0d want %0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_div_zero;
    logic [QW-1:0] q; logic [RW-1:0] r; logic dz; int lat;
    do_op(19'h12345, 10'h000, q, r, dz, lat);
    n_assert += 4;
    if (q !== '0) begin n_fail++; $display("FAIL dz_q got %h want 0", q); end
    if (r !== '0) begin n_fail++; $display("FAIL dz_r got %h want 0", r); end
    if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", dz); end
    if (lat != 2) begin n_fail++; $display("FAIL dz_lat got %0d want 2", lat); end
  endtask

  task automatic test_round_trip;
    logic [QW-1:0] q; logic [RW-1:0] r; logic dz; int lat;
    logic [31:0] x, y, a;
    for (int i = 0; i < 250; i++) begin
      x = 32'($urandom_range(0, 1023));
      y = 32'($urandom_range(1, 1023));
      a = clmul(x, y);
      do_op(a[DW-1:0], y[VW-1:0], q, r, dz, lat);
      n_assert++;
      if (q !== x[QW-1:0] || r !== '0 || dz !== 1'b0 || lat != DW + 2 * (VW - 1 - degree(y)) + 2) begin
        n_fail++;
        $display("FAIL roundtrip x=%h y=%h got q=%h r=%h dz=%b lat=%0d want q=%h r=0 lat=%0d",
                 x, y, q, r, dz, lat, x, DW + 2 * (VW - 1 - degree(y)) + 2);
      end
    end
  endtask

  task automatic test_random_model;
    logic [QW-1:0] q; logic [RW-1:0] r; logic dz; int lat;
    logic [31:0] a, b, recon;
    for (int i = 0; i < 250; i++) begin
      a = 32'($urandom_range(0, (1 << DW) - 1));
      b = 32'($urandom_range(1, 1023));
      do_op(a[DW-1:0], b[VW-1:0], q, r, dz, lat);
      recon = clmul({13'd0, q}, b) ^ {23'd0, r};
      n_assert++;
      if (recon !== a || degree({23'd0, r}) >= degree(b) || dz !== 1'b0 || lat < 0) begin
        n_fail++;
        $display("FAIL random a=%h b=%h got q=%h r=%h dz=%b lat=%0d recon=%h want recon=a deg r<%0d",
                 a, b, q, r, dz, lat, recon, degree(b));
      end
    end
  endtask

  // start_i pulsed with junk throughout the busy period, including DONE.
  task automatic test_start_ignored;
    int nval, vcyc, rdy_bad;
    logic [QW-1:0] q; logic [RW-1:0] r;
    @(posedge clk); #1;
    start_i = 1'b1; dividend_i = 19'h00007; divisor_i = 10'h003;
    @(posedge clk); #1;
    nval = 0; vcyc = -1; rdy_bad = 0; q = '0; r = '0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      start_i = (cyc <= 37) ? cyc[0] | (cyc == 37) : 1'b0;
      dividend_i = 19'h7FFFF; divisor_i = 10'h001;
      if (valid_o) begin nval++; vcyc = cyc; q = quotient_o; r = remainder_o; end
      if (cyc <= 37 && ready_o !== 1'b0) rdy_bad++;
      if (cyc == 38 && ready_o !== 1'b1) rdy_bad++;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    n_assert += 4;
    if (nval != 1) begin n_fail++; $display("FAIL ign_count got %0d want 1", nval); end
    if (vcyc != 37) begin n_fail++; $display("FAIL ign_lat got %0d want 37", vcyc); end
    if (q !== 19'h2 || r !== 9'h1) begin n_fail++; $display("FAIL ign_result got q=%h r=%h want q=2 r=1", q, r); end
    if (rdy_bad != 0) begin n_fail++; $display("FAIL ign_ready got %0d bad cycles want 0", rdy_bad); end
  endtask

  // start_i held high until the second acceptance at cycle 22.
  task automatic test_back_to_back;
    int nval, v0, v1;
    @(posedge clk); #1;
    start_i = 1'b1; dividend_i = 19'h40000; divisor_i = 10'h200;
    @(posedge clk); #1;
    nval = 0; v0 = -1; v1 = -1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (cyc == 23) start_i = 1'b0;
      if (valid_o) begin
        nval++;
        if (v0 < 0) v0 = cyc; else v1 = cyc;
      end
      @(posedge clk); #1;
    end
    n_assert += 3;
    if (nval != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", nval); end
    if (v0 != 21) begin n_fail++; $display("FAIL b2b_first got %0d want 21", v0); end
    if (v1 != 43) begin n_fail++; $display("FAIL b2b_second got %0d want 43", v1); end
  endtask

  task automatic test_reset_mid;
    int nval;
    logic [QW-1:0] q; logic [RW-1:0] r; logic dz; int lat;
    @(posedge clk); #1;
    start_i = 1'b1; dividend_i = 19'h7FFFF; divisor_i = 10'h001;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_assert += 4;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", ready_o); end
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", valid_o); end
    if (quotient_o !== '0 || remainder_o !== '0) begin
      n_fail++; $display("FAIL rmid_out got q=%h r=%h want 0 0", quotient_o, remainder_o);
    end
    nval = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (valid_o) nval++;
      @(posedge clk); #1;
    end
    if (nval != 0) begin n_fail++; $display("FAIL rmid_novalid got %0d want 0", nval); end
    do_op(19'h7FFFF, 10'h001, q, r, dz, lat);
    n_assert += 2;
    if (q !== 19'h7FFFF || r !== '0 || dz !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after got q=%h r=%h dz=%b want q=7ffff r=0 dz=0", q, r, dz);
    end
    if (lat != 39) begin n_fail++; $display("FAIL rmid_after_lat got %0d want 39", lat); end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_div_zero();
    test_round_trip();
    test_random_model();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
